// File: rtl/sum4_arbiter.sv
// sum4_arbiter: round-robin share of one 4-input adder tree, with returned sums routed back by a tag pipe.
// SUM4_ARB_PRIORITY_EN gives requester 0 strict priority over the round-robin group.
module sum4_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2,
   parameter int LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*128-1:0] req_data,
   output logic [NUM_REQ-1:0]     gnt,
   output logic                   dp_valid,
   output logic [31:0]            dp_data_0,
   output logic [31:0]            dp_data_1,
   output logic [31:0]            dp_data_2,
   output logic [31:0]            dp_data_3,
   input  logic                   dp_res_valid,
   input  logic [31:0]            dp_res_data,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [31:0]            rsp_data,
   output logic                   busy,
   output logic                   err
);
   logic [IDX_W-1:0] ptr, gnt_idx, iss_idx, cand;
   logic [NUM_REQ-1:0] rr_req;
   logic rr_hit, pri_hit, arb_en;
   logic [127:0] sel_data;
   logic [LATENCY-1:0] tag_v;
   logic [IDX_W-1:0] tag_i [LATENCY];

   assign arb_en = en && rst;
`ifdef SUM4_ARB_PRIORITY_EN
   assign pri_hit = arb_en && req[0];
   assign rr_req = pri_hit ? '0 : {req[NUM_REQ-1:1], 1'b0};
`else
   assign pri_hit = 1'b0;
   assign rr_req = req;
`endif

   always_comb begin
      rr_hit = 1'b0;
      gnt_idx = '0;
      cand = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (!rr_hit && arb_en && rr_req[cand]) begin
            rr_hit = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign gnt = (rr_hit || pri_hit) ? NUM_REQ'(1) << gnt_idx : '0;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gnt[i]) sel_data = req_data[128*i +: 128];
   end

   // priority grants leave the pointer alone so the round-robin group keeps its order
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= IDX_W'(NUM_REQ - 1);
         dp_valid <= 1'b0;
         iss_idx <= '0;
         {dp_data_3, dp_data_2, dp_data_1, dp_data_0} <= '0;
      end else begin
         if (rr_hit) ptr <= gnt_idx;
         dp_valid <= |gnt;
         if (|gnt) begin
            iss_idx <= gnt_idx;
            {dp_data_3, dp_data_2, dp_data_1, dp_data_0} <= sel_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_v <= '0;
         for (int i = 0; i < LATENCY; i++) tag_i[i] <= '0;
      end else begin
         tag_v[0] <= dp_valid;
         tag_i[0] <= iss_idx;
         for (int i = 1; i < LATENCY; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_i[i] <= tag_i[i-1];
         end
      end
   end

   // any disagreement between the head tag and dp_res_valid is a lost or orphan result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= '0;
         rsp_data <= '0;
         err <= 1'b0;
      end else begin
         rsp_valid <= (dp_res_valid && tag_v[LATENCY-1]) ? NUM_REQ'(1) << tag_i[LATENCY-1] : '0;
         if (dp_res_valid && tag_v[LATENCY-1]) rsp_data <= dp_res_data;
         err <= err | (dp_res_valid ^ tag_v[LATENCY-1]);
      end
   end

   assign busy = dp_valid | (|tag_v);
endmodule

// File: tb/tb_sum4_arbiter.sv
// tb_sum4_arbiter: randomized bench with a scoreboard model of grants, issue and tagged returns.
// The bench plays the adder tree as an integer 4-way adder with the configured latency.
module tb_sum4_arbiter;
   localparam int N = 4;
   localparam int LAT = 2;

   logic clk = 1'b0, rst = 1'b0, en = 1'b0;
   logic [N-1:0] req = '0;
   logic [N*128-1:0] req_data = '0;
   logic [N-1:0] gnt, rsp_valid;
   logic dp_valid, busy, err;
   logic [31:0] dp_data_0, dp_data_1, dp_data_2, dp_data_3, rsp_data;
   logic dp_res_valid = 1'b0;
   logic [31:0] dp_res_data = '0;

   sum4_arbiter #(.NUM_REQ(N), .IDX_W(2), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data), .gnt(gnt),
      .dp_valid(dp_valid), .dp_data_0(dp_data_0), .dp_data_1(dp_data_1),
      .dp_data_2(dp_data_2), .dp_data_3(dp_data_3), .dp_res_valid(dp_res_valid),
      .dp_res_data(dp_res_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {int idx; logic [31:0] sum; int t;} op_t;
   op_t q[$];
   int checks = 0, errors = 0;
   int cyc = 0, last = N - 1, prev_g = -1;
   logic exp_dpv = 1'b0, exp_err = 1'b0, inject = 1'b0;
   logic [127:0] exp_dpd = '0;
   logic [31:0] exp_rd = '0;
   logic [N-1:0] nreq = '0;
   logic nen = 1'b0;
   logic [N*128-1:0] ndata = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] sum4(input logic [127:0] d);
      return d[31:0] + d[63:32] + d[95:64] + d[127:96];
   endfunction

   function automatic logic [127:0] rnd_ops();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // mode 0: apply nreq/nen/ndata; 1: random handshaking requesters; 2: all requesting
   task automatic step(input int mode);
      int g, lo;
      logic [N-1:0] eg, erv;
      logic eb;
      @(negedge clk);
      if (mode == 0) begin
         req = nreq; en = nen; req_data = ndata;
      end else begin
         if (prev_g >= 0) begin
            req[prev_g] = (mode == 2) ? 1'b1 : 1'($urandom % 2);
            req_data[128*prev_g +: 128] = rnd_ops();
         end
         for (int i = 0; i < N; i++)
            if (!req[i] && (mode == 2 || $urandom % 4 == 0)) begin
               req[i] = 1'b1;
               req_data[128*i +: 128] = rnd_ops();
            end
         en = (mode == 2) ? 1'b1 : ($urandom % 4 != 0);
      end
      dp_res_valid = inject;
      dp_res_data = $urandom;
      foreach (q[i])
         if (q[i].t + LAT + 1 == cyc) begin
            dp_res_valid = 1'b1;
            dp_res_data = q[i].sum;
         end
      #1;
      g = -1;
      lo = 0;
`ifdef SUM4_ARB_PRIORITY_EN
      lo = 1;
      if (en && req[0]) g = 0;
`endif
      if (en)
         for (int k = 1; k <= N; k++)
            if (g < 0 && (last + k) % N >= lo && req[(last + k) % N]) g = (last + k) % N;
      eg = (g < 0) ? '0 : N'(1) << g;
      check("gnt", gnt, eg);
      check("dp_valid", dp_valid, exp_dpv);
      check("dp_data", {dp_data_3, dp_data_2, dp_data_1, dp_data_0}, exp_dpd);
      eb = 1'b0;
      foreach (q[i]) if (q[i].t < cyc && cyc < q[i].t + LAT + 2) eb = 1'b1;
      check("busy", busy, eb);
      erv = '0;
      if (q.size() > 0 && q[0].t + LAT + 2 == cyc) begin
         erv = N'(1) << q[0].idx;
         exp_rd = q[0].sum;
         void'(q.pop_front());
      end
      check("rsp_valid", rsp_valid, erv);
      check("rsp_data", rsp_data, exp_rd);
      check("err", err, exp_err);
      exp_dpv = (g >= 0);
      if (g >= 0) begin
         exp_dpd = req_data[128*g +: 128];
         q.push_back('{g, sum4(exp_dpd), cyc});
         if (g >= lo) last = g;
      end
      if (inject) exp_err = 1'b1;
      prev_g = g;
      cyc++;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_gnt"}, gnt, 0);
      check({tag, "_dp_valid"}, dp_valid, 0);
      check({tag, "_dp_data"}, {dp_data_3, dp_data_2, dp_data_1, dp_data_0}, 0);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_data"}, rsp_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err"}, err, 0);
   endtask

   initial begin
      req = '1;
      en = 1'b1;
      repeat (2) @(negedge clk);
      #1 check_zero("reset");
      req = '0;
      rst = 1'b1;
      // single op with FP32 1.0, 2.0, 3.0, 4.0 on requester 2
      nen = 1'b1;
      nreq = 4'b0100;
      ndata[128*2 +: 128] = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
      step(0);
      nreq = '0;
      repeat (6) step(0);
      // everyone requesting continuously
      repeat (14) step(2);
      // held requests with en low, then released
      nreq = '1;
      nen = 1'b0;
      ndata = req_data;
      repeat (5) step(0);
      nen = 1'b1;
      repeat (3) step(0);
      nreq = '0;
      repeat (6) step(0);
      repeat (400) step(1);
      nreq = '0;
      nen = 1'b1;
      ndata = req_data;
      repeat (6) step(0);
      // reset with two ops in flight and a stray result inside the reset window
      nreq = '1;
      repeat (2) step(0);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check_zero("midrst");
      dp_res_valid = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("rstwin");
      req = '0;
      dp_res_valid = 1'b0;
      rst = 1'b1;
      q.delete();
      last = N - 1;
      prev_g = -1;
      exp_dpv = 1'b0;
      exp_dpd = '0;
      exp_rd = '0;
      exp_err = 1'b0;
      nreq = '0;
      repeat (6) step(0);
      // orphan result with an empty tag pipe
      inject = 1'b1;
      step(0);
      inject = 1'b0;
      repeat (4) step(0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("err_clear", err, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
